// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - request inputs, lamp and countdown outputs of the traffic-light controller
interface traffic_light_ctrl_if;
  logic        night;
  logic        req_ns;
  logic        req_we;
  logic [15:0] data;
  logic [2:0]  out_LED3_NS;
  logic [2:0]  out_LED3_WE;
  logic [2:0]  phase;

  modport master (
    output night, req_ns, req_we,
    input  data, out_LED3_NS, out_LED3_WE, phase
  );

  modport slave (
    input  night, req_ns, req_we,
    output data, out_LED3_NS, out_LED3_WE, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road traffic-light controller with BCD countdown, truncation and night flash
module traffic_light_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_NS  = 20,
  parameter int GREEN_WE  = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int SHORT_T   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED1  = 3'd2,
    WE_G  = 3'd3,
    WE_Y  = 3'd4,
    RED2  = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] c);
    if (c[3:0] == 4'd0) bcd_dec = {c[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {c[7:4], c[3:0] - 4'd1};
  endfunction

  // Phase loads are D-1 so that every phase spans exactly D ticks.
  localparam logic [7:0] LD_GNS   = to_bcd(GREEN_NS - 1);
  localparam logic [7:0] LD_GWE   = to_bcd(GREEN_WE - 1);
  localparam logic [7:0] LD_Y     = to_bcd(YELLOW_T - 1);
  localparam logic [7:0] LD_AR    = to_bcd(ALL_RED_T - 1);
  localparam logic [7:0] LD_SHORT = to_bcd(SHORT_T - 1);

  logic [DIV_W-1:0] div_q, div_d;
  state_t           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic             latch_ns_q, latch_ns_d;
  logic             latch_we_q, latch_we_d;
  logic [2:0]       led_ns_q, led_ns_d;
  logic [2:0]       led_we_q, led_we_d;
  logic [15:0]      data_q, data_d;
  logic [2:0]       phase_q, phase_d;
  logic             tick;
  logic             ns_entry;
  logic             we_entry;
  logic             truncate;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    state_d  = state_q;
    count_d  = count_q;
    truncate = ((state_q == NS_G) && latch_we_q) || ((state_q == WE_G) && latch_ns_q);

    // Night has priority over both advance and truncation.
    if (tick) begin
      if (bus.night && (state_q != FLASH)) begin
        state_d = FLASH;
        count_d = 8'h00;
      end else if (state_q == FLASH) begin
        if (!bus.night) begin
          state_d = RED2;
          count_d = LD_AR;
        end
      end else if (count_q == 8'h00) begin
        case (state_q)
          NS_G:    begin state_d = NS_Y; count_d = LD_Y;   end
          NS_Y:    begin state_d = RED1; count_d = LD_AR;  end
          RED1:    begin state_d = WE_G; count_d = LD_GWE; end
          WE_G:    begin state_d = WE_Y; count_d = LD_Y;   end
          WE_Y:    begin state_d = RED2; count_d = LD_AR;  end
          default: begin state_d = NS_G; count_d = LD_GNS; end
        endcase
      end else if (truncate && (count_q > LD_SHORT)) begin
        count_d = LD_SHORT;
      end else begin
        count_d = bcd_dec(count_q);
      end
    end

    ns_entry   = (state_d == NS_G) && (state_q != NS_G);
    we_entry   = (state_d == WE_G) && (state_q != WE_G);
    latch_ns_d = bus.req_ns | (latch_ns_q & ~ns_entry);
    latch_we_d = bus.req_we | (latch_we_q & ~we_entry);

    led_ns_d = led_ns_q;
    led_we_d = led_we_q;
    case (state_d)
      NS_G:    begin led_ns_d = LAMP_GRN; led_we_d = LAMP_RED; end
      NS_Y:    begin led_ns_d = LAMP_YEL; led_we_d = LAMP_RED; end
      WE_G:    begin led_ns_d = LAMP_RED; led_we_d = LAMP_GRN; end
      WE_Y:    begin led_ns_d = LAMP_RED; led_we_d = LAMP_YEL; end
      FLASH: begin
        if (state_q != FLASH) begin
          led_ns_d = LAMP_YEL;
          led_we_d = LAMP_YEL;
        end else if (tick) begin
          led_ns_d = led_ns_q ^ LAMP_YEL;
          led_we_d = led_we_q ^ LAMP_YEL;
        end
      end
      default: begin led_ns_d = LAMP_RED; led_we_d = LAMP_RED; end
    endcase

    data_d  = (state_d == FLASH) ? 16'h0000 : {count_d, count_d};
    phase_d = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      state_q    <= RED2;
      count_q    <= 8'h00;
      latch_ns_q <= 1'b0;
      latch_we_q <= 1'b0;
      led_ns_q   <= LAMP_RED;
      led_we_q   <= LAMP_RED;
      data_q     <= 16'h0000;
      phase_q    <= 3'd5;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      count_q    <= count_d;
      latch_ns_q <= latch_ns_d;
      latch_we_q <= latch_we_d;
      led_ns_q   <= led_ns_d;
      led_we_q   <= led_we_d;
      data_q     <= data_d;
      phase_q    <= phase_d;
    end
  end

  assign bus.data        = data_q;
  assign bus.out_LED3_NS = led_ns_q;
  assign bus.out_LED3_WE = led_we_q;
  assign bus.phase       = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;
  localparam int TD  = 4;
  localparam int GNS = 5;
  localparam int GWE = 4;
  localparam int YT  = 2;
  localparam int ART = 1;
  localparam int ST  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl #(
    .TICK_DIV (TD),
    .GREEN_NS (GNS),
    .GREEN_WE (GWE),
    .YELLOW_T (YT),
    .ALL_RED_T(ART),
    .SHORT_T  (ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number, remaining ticks as a plain integer, lamps from tables.
  int         dur [6]         = '{GNS, YT, ART, GWE, YT, ART};
  logic [2:0] lamp_ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] lamp_we_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int         m_clk_cnt;
  int         m_phase;
  int         m_rem;
  bit         m_lat_ns;
  bit         m_lat_we;
  logic [2:0] m_flash;

  always @(posedge clk or posedge rst) begin
    int  prev;
    bit  tk;
    if (rst) begin
      m_clk_cnt = 0;
      m_phase   = 5;
      m_rem     = 0;
      m_lat_ns  = 1'b0;
      m_lat_we  = 1'b0;
      m_flash   = 3'b010;
    end else begin
      m_clk_cnt = m_clk_cnt + 1;
      tk        = (m_clk_cnt % TD) == 0;
      prev      = m_phase;
      if (tk) begin
        if (bus.night && m_phase != 6) begin
          m_phase = 6;
          m_rem   = 0;
          m_flash = 3'b010;
        end else if (m_phase == 6) begin
          if (!bus.night) begin
            m_phase = 5;
            m_rem   = ART - 1;
          end else begin
            m_flash = (m_flash == 3'b010) ? 3'b000 : 3'b010;
          end
        end else if (m_rem == 0) begin
          m_phase = (m_phase + 1) % 6;
          m_rem   = dur[m_phase] - 1;
        end else if (((m_phase == 0 && m_lat_we) || (m_phase == 3 && m_lat_ns)) && m_rem > ST - 1) begin
          m_rem = ST - 1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      m_lat_ns = bus.req_ns || (m_lat_ns && !(m_phase == 0 && prev != 0));
      m_lat_we = bus.req_we || (m_lat_we && !(m_phase == 3 && prev != 3));
    end
  end

  always @(negedge clk) begin
    logic [7:0]  b;
    logic [15:0] exp_data;
    logic [2:0]  exp_ns;
    logic [2:0]  exp_we;
    logic        guard_ok;
    b        = 8'(((m_rem / 10) * 16) + (m_rem % 10));
    exp_data = (m_phase == 6) ? 16'h0000 : {b, b};
    exp_ns   = (m_phase == 6) ? m_flash : lamp_ns_tab[m_phase];
    exp_we   = (m_phase == 6) ? m_flash : lamp_we_tab[m_phase];
    chk("model_phase", 16'(bus.phase), 16'(m_phase));
    chk("model_data", bus.data, exp_data);
    chk("model_lamp_ns", 16'(bus.out_LED3_NS), 16'(exp_ns));
    chk("model_lamp_we", 16'(bus.out_LED3_WE), 16'(exp_we));
    guard_ok = (bus.phase == 3'd6) || (bus.out_LED3_NS == 3'b100) || (bus.out_LED3_WE == 3'b100);
    chk("red_guard", 16'(guard_ok), 16'd1);
  end

  task automatic ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [2:0] ph, input logic [15:0] d,
                     input logic [2:0] ns, input logic [2:0] we);
    chk({name, "_phase"}, 16'(bus.phase), 16'(ph));
    chk({name, "_data"}, bus.data, d);
    chk({name, "_ns"}, 16'(bus.out_LED3_NS), 16'(ns));
    chk({name, "_we"}, 16'(bus.out_LED3_WE), 16'(we));
  endtask

  initial begin
    bus.night  = 1'b0;
    bus.req_ns = 1'b0;
    bus.req_we = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset", 3'd5, 16'h0000, 3'b100, 3'b100);
    rst = 1'b0;

    // Plain cycle: t counts ticks since release.
    ticks(1);  lit("t1_nsg", 3'd0, 16'h0404, 3'b001, 3'b100);
    ticks(1);  lit("t2_nsg", 3'd0, 16'h0303, 3'b001, 3'b100);
    ticks(7);  lit("t9_weg", 3'd3, 16'h0303, 3'b100, 3'b001);
    ticks(7);  lit("t16_nsg", 3'd0, 16'h0404, 3'b001, 3'b100);

    // Cross request truncates WE_G.
    ticks(8);  lit("t24_weg", 3'd3, 16'h0303, 3'b100, 3'b001);
    bus.req_ns = 1'b1;
    @(negedge clk);
    bus.req_ns = 1'b0;
    repeat (TD - 1) @(negedge clk);
    lit("t25_trunc", 3'd3, 16'h0101, 3'b100, 3'b001);
    ticks(1);  lit("t26_weg0", 3'd3, 16'h0000, 3'b100, 3'b001);
    ticks(1);  lit("t27_wey", 3'd4, 16'h0101, 3'b100, 3'b010);
    ticks(12); lit("t39_untrunc", 3'd3, 16'h0202, 3'b100, 3'b001);

    // req_we held through NS_G entry shortens NS_G to 3 ticks.
    ticks(4);
    bus.req_we = 1'b1;
    ticks(2);  lit("t45_nsg", 3'd0, 16'h0404, 3'b001, 3'b100);
    ticks(1);  lit("t46_trunc", 3'd0, 16'h0101, 3'b001, 3'b100);
    bus.req_we = 1'b0;
    ticks(2);  lit("t48_nsy", 3'd1, 16'h0101, 3'b010, 3'b100);

    // Night mode mid NS_G.
    ticks(11); lit("t59_nsg", 3'd0, 16'h0303, 3'b001, 3'b100);
    bus.night = 1'b1;
    ticks(1);  lit("flash_on", 3'd6, 16'h0000, 3'b010, 3'b010);
    ticks(1);  lit("flash_off", 3'd6, 16'h0000, 3'b000, 3'b000);
    ticks(1);  lit("flash_on2", 3'd6, 16'h0000, 3'b010, 3'b010);
    bus.night = 1'b0;
    ticks(1);  lit("flash_exit", 3'd5, 16'h0000, 3'b100, 3'b100);
    ticks(1);  lit("resume_nsg", 3'd0, 16'h0404, 3'b001, 3'b100);

    // Asynchronous reset mid WE_Y.
    ticks(12); lit("t76_wey", 3'd4, 16'h0101, 3'b100, 3'b010);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 lit("async_rst", 3'd5, 16'h0000, 3'b100, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    repeat (TD - 1) @(negedge clk);
    lit("pre_entry", 3'd5, 16'h0000, 3'b100, 3'b100);
    // Request in the same clock as NS_G entry must survive.
    bus.req_ns = 1'b1;
    @(negedge clk);
    bus.req_ns = 1'b0;
    lit("entry_4clk", 3'd0, 16'h0404, 3'b001, 3'b100);
    ticks(8);  lit("r9_weg", 3'd3, 16'h0303, 3'b100, 3'b001);
    // Request coinciding with the truncating tick.
    repeat (TD - 1) @(negedge clk);
    bus.req_ns = 1'b1;
    @(negedge clk);
    bus.req_ns = 1'b0;
    lit("r10_trunc", 3'd3, 16'h0101, 3'b100, 3'b001);
    ticks(2);  lit("r12_wey", 3'd4, 16'h0101, 3'b100, 3'b010);
    ticks(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
